// File: rtl/wb_scoreboard_arbiter_if.sv
// Issue, writeback-request and register-file write bundle for wb_scoreboard_arbiter.
// The master modport is the driving side (decode/units); the slave modport is the scoreboard.
interface wb_scoreboard_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_iss_valid;
    logic [4:0]      i_iss_rs1;
    logic [4:0]      i_iss_rs2;
    logic [4:0]      i_iss_rd;
    logic            i_iss_rd_we;
    logic            o_iss_stall;

    logic            i_alu_valid;
    logic            o_alu_ready;
    logic [4:0]      i_alu_rd;
    logic [XLEN-1:0] i_alu_wdata;

    logic            i_lsu_valid;
    logic            o_lsu_ready;
    logic [4:0]      i_lsu_rd;
    logic [XLEN-1:0] i_lsu_wdata;

    logic            o_rd_wvalid;
    logic [4:0]      o_rd_waddr;
    logic [XLEN-1:0] o_rd_wdata;

    logic [31:0]     o_busy;

    modport master (
        output i_iss_valid, i_iss_rs1, i_iss_rs2, i_iss_rd, i_iss_rd_we,
        output i_alu_valid, i_alu_rd, i_alu_wdata,
        output i_lsu_valid, i_lsu_rd, i_lsu_wdata,
        input  o_iss_stall, o_alu_ready, o_lsu_ready,
        input  o_rd_wvalid, o_rd_waddr, o_rd_wdata, o_busy
    );

    modport slave (
        input  i_iss_valid, i_iss_rs1, i_iss_rs2, i_iss_rd, i_iss_rd_we,
        input  i_alu_valid, i_alu_rd, i_alu_wdata,
        input  i_lsu_valid, i_lsu_rd, i_lsu_wdata,
        output o_iss_stall, o_alu_ready, o_lsu_ready,
        output o_rd_wvalid, o_rd_waddr, o_rd_wdata, o_busy
    );
endinterface

// File: rtl/wb_scoreboard_arbiter.sv
// Register scoreboard with issue-hazard stall and a two-channel writeback arbiter (LSU/ALU).
// Optional macro WB_RR_ARB_EN selects round-robin arbitration instead of fixed LSU priority.
//
// state     | meaning (WB_RR_ARB_EN only)
// PREF_LSU  | LSU wins when both channels request
// PREF_ALU  | ALU wins when both channels request
module wb_scoreboard_arbiter #(
    parameter int XLEN = 32
) (
    input logic                   clk,
    input logic                   rstn,
    wb_scoreboard_arbiter_if.slave bus
);
    logic [31:0]     r_busy;
    logic [31:0]     w_busy_nxt;
    logic            r_wvalid;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;

    logic            w_stall;
    logic            w_iss_fire;
    logic            w_gnt_lsu;
    logic            w_gnt_alu;
    logic            w_xfer;
    logic [4:0]      w_wb_rd;
    logic [XLEN-1:0] w_wb_wdata;

    assign w_stall = bus.i_iss_valid &
                     (r_busy[bus.i_iss_rs1] | r_busy[bus.i_iss_rs2] |
                      (bus.i_iss_rd_we & r_busy[bus.i_iss_rd]));
    assign w_iss_fire = bus.i_iss_valid & ~w_stall;

`ifdef WB_RR_ARB_EN
    typedef enum logic {PREF_LSU = 1'b0, PREF_ALU = 1'b1} pref_e;
    pref_e r_pref;
    pref_e w_pref_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_pref <= PREF_LSU;
        else       r_pref <= w_pref_nxt;
    end

    always_comb begin
        w_pref_nxt = r_pref;
        w_gnt_lsu  = 1'b0;
        w_gnt_alu  = 1'b0;
        if (bus.i_lsu_valid && bus.i_alu_valid) begin
            if (r_pref == PREF_LSU) begin
                w_gnt_lsu  = 1'b1;
                w_pref_nxt = PREF_ALU;
            end else begin
                w_gnt_alu  = 1'b1;
                w_pref_nxt = PREF_LSU;
            end
        end else begin
            w_gnt_lsu = bus.i_lsu_valid;
            w_gnt_alu = bus.i_alu_valid;
        end
    end
`else
    always_comb begin
        w_gnt_lsu = bus.i_lsu_valid;
        w_gnt_alu = bus.i_alu_valid & ~bus.i_lsu_valid;
    end
`endif

    // Grants depend only on valids and pointer; reset gating keeps readies low while held in reset.
    assign bus.o_lsu_ready = rstn & w_gnt_lsu;
    assign bus.o_alu_ready = rstn & w_gnt_alu;

    assign w_xfer     = w_gnt_lsu | w_gnt_alu;
    assign w_wb_rd    = w_gnt_lsu ? bus.i_lsu_rd    : bus.i_alu_rd;
    assign w_wb_wdata = w_gnt_lsu ? bus.i_lsu_wdata : bus.i_alu_wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wvalid <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_wvalid <= w_xfer && (w_wb_rd != 5'd0);
            if (w_xfer && (w_wb_rd != 5'd0)) begin
                r_waddr <= w_wb_rd;
                r_wdata <= w_wb_wdata;
            end
        end
    end

    // Clear applied before set so a same-edge issue to the retiring register stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wvalid) w_busy_nxt[r_waddr] = 1'b0;
        if (w_iss_fire && bus.i_iss_rd_we && (bus.i_iss_rd != 5'd0))
            w_busy_nxt[bus.i_iss_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_busy <= '0;
        else       r_busy <= w_busy_nxt;
    end

    assign bus.o_iss_stall = w_stall;
    assign bus.o_rd_wvalid = r_wvalid;
    assign bus.o_rd_waddr  = r_waddr;
    assign bus.o_rd_wdata  = r_wdata;
    assign bus.o_busy      = r_busy;
endmodule

// File: tb/tb_wb_scoreboard_arbiter.sv
// Directed bench for wb_scoreboard_arbiter: expected writes queued when stimulus is driven,
// popped and compared whenever the register-file write port fires.
module tb_wb_scoreboard_arbiter;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    logic [36:0] exp_q[$];

    wb_scoreboard_arbiter_if #(.XLEN(32)) bus ();

    wb_scoreboard_arbiter #(.XLEN(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write-port monitor, sampled on the falling edge away from input changes.
    always @(negedge clk) begin
        if (rstn && bus.o_rd_wvalid) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", {59'd0, bus.o_rd_waddr}, 64'h0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("wb_addr", {59'd0, bus.o_rd_waddr}, {59'd0, e[36:32]});
                chk("wb_data", {32'd0, bus.o_rd_wdata}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        int li;
        int ai;
        logic exp_lsu;
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        bus.i_iss_valid = 0; bus.i_iss_rs1 = 0; bus.i_iss_rs2 = 0;
        bus.i_iss_rd = 0;    bus.i_iss_rd_we = 0;
        bus.i_alu_valid = 1; bus.i_alu_rd = 5'd1; bus.i_alu_wdata = 32'h1;
        bus.i_lsu_valid = 1; bus.i_lsu_rd = 5'd2; bus.i_lsu_wdata = 32'h2;
        tick(); tick();
        #1;
        chk("rst_busy",   bus.o_busy, 0);
        chk("rst_wvalid", bus.o_rd_wvalid, 0);
        chk("rst_waddr",  bus.o_rd_waddr, 0);
        chk("rst_wdata",  bus.o_rd_wdata, 0);
        chk("rst_alu_rdy", bus.o_alu_ready, 0);
        chk("rst_lsu_rdy", bus.o_lsu_ready, 0);
        bus.i_alu_valid = 0; bus.i_lsu_valid = 0;
        tick();
        rstn = 1'b1;
        tick();

        // RAW on x5 resolved by ALU writeback
        bus.i_iss_valid = 1; bus.i_iss_rd = 5'd5; bus.i_iss_rd_we = 1;
        #1 chk("raw_issue_nostall", bus.o_iss_stall, 0);
        tick();
        chk("raw_busy5", bus.o_busy, 32'h20);
        bus.i_iss_rs1 = 5'd5; bus.i_iss_rd = 5'd6;
        #1 chk("raw_stall", bus.o_iss_stall, 1);
        tick();
        chk("raw_busy_held", bus.o_busy, 32'h20);
        bus.i_alu_valid = 1; bus.i_alu_rd = 5'd5; bus.i_alu_wdata = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        #1 chk("raw_alu_ready", bus.o_alu_ready, 1);
        chk("raw_stall_grant", bus.o_iss_stall, 1);
        tick();
        bus.i_alu_valid = 0;
        #1 chk("raw_wvalid", bus.o_rd_wvalid, 1);
        chk("raw_waddr", bus.o_rd_waddr, 5);
        chk("raw_stall_wb", bus.o_iss_stall, 1);
        tick();
        #1 chk("raw_stall_drop", bus.o_iss_stall, 0);
        chk("raw_wvalid_off", bus.o_rd_wvalid, 0);
        tick();
        bus.i_iss_valid = 0; bus.i_iss_rs1 = 0; bus.i_iss_rd_we = 0;
        chk("raw_busy6", bus.o_busy, 32'h40);

        // Simultaneous requests to non-busy registers: LSU first either way (pointer starts at LSU)
        bus.i_alu_valid = 1; bus.i_alu_rd = 5'd3; bus.i_alu_wdata = 32'hA3A3A3A3;
        bus.i_lsu_valid = 1; bus.i_lsu_rd = 5'd4; bus.i_lsu_wdata = 32'hB4B4B4B4;
        exp_q.push_back({5'd4, 32'hB4B4B4B4});
        exp_q.push_back({5'd3, 32'hA3A3A3A3});
        #1 chk("both_lsu_rdy", bus.o_lsu_ready, 1);
        chk("both_alu_rdy", bus.o_alu_ready, 0);
        tick();
        bus.i_lsu_valid = 0;
        #1 chk("both_addr4", bus.o_rd_waddr, 4);
        chk("both_alu_rdy2", bus.o_alu_ready, 1);
        tick();
        bus.i_alu_valid = 0;
        chk("both_wvalid3", bus.o_rd_wvalid, 1);
        chk("both_addr3", bus.o_rd_waddr, 3);
        tick();
        chk("clean_wb_busy", bus.o_busy, 32'h40);

        // Retire x6
        bus.i_alu_valid = 1; bus.i_alu_rd = 5'd6; bus.i_alu_wdata = 32'h66;
        exp_q.push_back({5'd6, 32'h66});
        tick();
        bus.i_alu_valid = 0;
        tick(); tick();
        chk("busy_clear6", bus.o_busy, 0);

        // x0 never busy, x0 writeback consumed silently
        bus.i_iss_valid = 1; bus.i_iss_rd = 5'd0; bus.i_iss_rd_we = 1;
        tick();
        bus.i_iss_valid = 0; bus.i_iss_rd_we = 0;
        chk("x0_busy", bus.o_busy, 0);
        bus.i_alu_valid = 1; bus.i_alu_rd = 5'd0; bus.i_alu_wdata = 32'h1234;
        #1 chk("x0_alu_ready", bus.o_alu_ready, 1);
        tick();
        bus.i_alu_valid = 0;
        #1 chk("x0_wvalid", bus.o_rd_wvalid, 0);
        chk("x0_busy2", bus.o_busy, 0);

        // WAW stall on x7
        bus.i_iss_valid = 1; bus.i_iss_rd = 5'd7; bus.i_iss_rd_we = 1;
        tick();
        chk("waw_busy7", bus.o_busy, 32'h80);
        #1 chk("waw_stall", bus.o_iss_stall, 1);
        bus.i_iss_rd_we = 0;
        #1 chk("nowe_nostall", bus.o_iss_stall, 0);
        bus.i_iss_rs2 = 5'd7;
        #1 chk("rs2_stall", bus.o_iss_stall, 1);
        bus.i_iss_rs2 = 5'd0;
        tick();
        bus.i_iss_valid = 0;
        chk("nowe_busy", bus.o_busy, 32'h80);

        // Same-edge clear (write to non-busy x9) and set (issue rd=9): set wins
        bus.i_alu_valid = 1; bus.i_alu_rd = 5'd9; bus.i_alu_wdata = 32'h99;
        exp_q.push_back({5'd9, 32'h99});
        tick();
        bus.i_alu_valid = 0;
        bus.i_iss_valid = 1; bus.i_iss_rd = 5'd9; bus.i_iss_rd_we = 1;
        #1 chk("setclr_nostall", bus.o_iss_stall, 0);
        tick();
        bus.i_iss_valid = 0; bus.i_iss_rd_we = 0;
        tick();
        chk("setclr_busy", bus.o_busy, 32'h280);

        // Reset right after a grant drops the in-flight write
        bus.i_alu_valid = 1; bus.i_alu_rd = 5'd7; bus.i_alu_wdata = 32'h77;
        tick();
        bus.i_alu_valid = 0;
        rstn = 1'b0;
        #1 chk("rstmid_wvalid", bus.o_rd_wvalid, 0);
        chk("rstmid_busy", bus.o_busy, 0);
        tick();
        rstn = 1'b1;
        tick(); tick();
        chk("rstmid_nowrite", bus.o_rd_wvalid, 0);
        chk("rstmid_q_empty", exp_q.size(), 0);

        // Both channels requesting for four cycles
        li = 0; ai = 0;
        bus.i_lsu_valid = 1; bus.i_alu_valid = 1;
        for (int c = 0; c < 4; c++) begin
            bus.i_lsu_rd = 5'(11 + li); bus.i_lsu_wdata = 32'h1100 + 32'(li);
            bus.i_alu_rd = 5'(21 + ai); bus.i_alu_wdata = 32'h2100 + 32'(ai);
`ifdef WB_RR_ARB_EN
            exp_lsu = (c % 2 == 0);
`else
            exp_lsu = 1'b1;
`endif
            #1 chk("arb_lsu_rdy", bus.o_lsu_ready, exp_lsu);
            chk("arb_alu_rdy", bus.o_alu_ready, !exp_lsu);
            if (exp_lsu) begin
                exp_q.push_back({5'(11 + li), 32'h1100 + 32'(li)});
                li++;
            end else begin
                exp_q.push_back({5'(21 + ai), 32'h2100 + 32'(ai)});
                ai++;
            end
            tick();
            if (c > 0) chk("arb_no_bubble", bus.o_rd_wvalid, 1);
        end
        bus.i_lsu_valid = 0; bus.i_alu_valid = 0;
        tick(); tick();
        chk("final_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
